// File: rtl/nvram_pkg.sv
// rtl/nvram_pkg.sv - shared constants for the NVRAM upload/restore block
//
// Purpose: state encoding, fill byte and default ioctl index used by
// nvram_uploader and nvram_rd_pipe. No ports.
package nvram_pkg;

    typedef logic [1:0] nv_state_t;

    localparam nv_state_t ST_IDLE  = 2'd0;
    localparam nv_state_t ST_PAUSE = 2'd1;
    localparam nv_state_t ST_READY = 2'd2;
    localparam nv_state_t ST_READ  = 2'd3;

    // Byte returned for reads past the end of the exposed area.
    localparam logic [7:0] NV_FILL = 8'hFF;

    // ioctl_index normally assigned to the NVRAM image.
    localparam logic [7:0] NV_DEFAULT_INDEX = 8'd4;

endpackage

// File: rtl/nvram_rd_pipe.sv
// rtl/nvram_rd_pipe.sv - RAM read latency counter and ioctl_din capture register
//
// Purpose: after start, waits RD_LAT+1 edges, then latches ram_rdata into din.
// Ports:
//   clk_sys, reset   clock, synchronous active-high reset
//   start            begin a read (RAM address is presented on the same edge)
//   cancel           abandon any read in flight; din keeps its value
//   fill             load NV_FILL into din (out-of-range read)
//   ram_rdata        NVRAM read data
//   done             high on the edge that captures ram_rdata
//   din              captured byte for the HPS
module nvram_rd_pipe
    import nvram_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       fill,
    input  logic [7:0] ram_rdata,
    output logic       done,
    output logic [7:0] din
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT);

    logic       busy;
    logic [1:0] cnt;

    // The address register takes one edge, the RAM RD_LAT more; data is
    // therefore sampled when the counter, loaded with RD_LAT, reaches zero.
    assign done = busy && (cnt == 2'd0);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= 2'd0;
            din  <= 8'h00;
        end else if (cancel) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= LAT_LOAD;
        end else if (fill) begin
            din <= NV_FILL;
        end else if (busy) begin
            if (cnt == 2'd0) begin
                din  <= ram_rdata;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/nvram_uploader.sv
// rtl/nvram_uploader.sv - NVRAM upload to HPS and restore from HPS over ioctl
//
// Purpose: while an ioctl session with index INDEX is open, halts the game CPU
// and serves ioctl_rd (upload) / ioctl_wr (restore) against NVRAM port B.
// Optional macro NVRAM_DIRTY_EN adds cpu_ram_we / nv_dirty change tracking.
// Ports:
//   clk_sys, reset                  clock, synchronous active-high reset
//   ioctl_upload/download/index     session control from hps_io
//   ioctl_rd/wr/addr/dout           HPS strobes, byte address, write data
//   ioctl_din, ioctl_wait           read data and stall to HPS
//   pause_req, pause_ack            game CPU halt handshake
//   ram_addr/wdata/we, ram_rdata    NVRAM port B
//   cpu_ram_we, nv_dirty            (NVRAM_DIRTY_EN only) game write seen since last save
module nvram_uploader
    import nvram_pkg::*;
#(
    parameter logic [7:0] INDEX  = NV_DEFAULT_INDEX,
    parameter int         AW     = 10,
    parameter int         SIZE   = 1024,
    parameter int         RD_LAT = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata
`ifdef NVRAM_DIRTY_EN
    ,
    input  logic          cpu_ram_we,
    output logic          nv_dirty
`endif
);

    localparam logic [24:0] SIZE_L = 25'(SIZE);

    nv_state_t state;

    logic sel;
    logic in_range;
    logic ready_ok;
    logic rd_start;
    logic rd_fill;
    logic wr_take;
    logic pipe_cancel;
    logic pipe_done;

    assign sel      = (ioctl_upload || ioctl_download) && (ioctl_index == INDEX);
    assign in_range = ioctl_addr < SIZE_L;

    // Strobes are honoured only in READY with the session open and the CPU halted.
    assign ready_ok = (state == ST_READY) && sel && pause_ack;
    assign rd_start = ready_ok && ioctl_rd && ioctl_upload && in_range;
    assign rd_fill  = ready_ok && ioctl_rd && !in_range;
    // Read has priority: a write strobe coinciding with a read is dropped.
    assign wr_take  = ready_ok && !ioctl_rd && ioctl_wr && ioctl_download && in_range;

    // Losing the session or the CPU halt abandons any read in flight.
    assign pipe_cancel = !sel || !pause_ack;

    nvram_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .start     (rd_start),
        .cancel    (pipe_cancel),
        .fill      (rd_fill),
        .ram_rdata (ram_rdata),
        .done      (pipe_done),
        .din       (ioctl_din)
    );

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ST_IDLE;
            ioctl_wait <= 1'b0;
            pause_req  <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 8'h00;
            ram_we     <= 1'b0;
        end else begin
            ram_we <= wr_take;
            if (rd_start || wr_take) begin
                ram_addr <= ioctl_addr[AW-1:0];
            end
            if (wr_take) begin
                ram_wdata <= ioctl_dout;
            end

            case (state)
                ST_IDLE: begin
                    if (sel) begin
                        pause_req  <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= ST_PAUSE;
                    end
                end
                default: begin
                    if (!sel) begin
                        state      <= ST_IDLE;
                        ioctl_wait <= 1'b0;
                        pause_req  <= 1'b0;
                    end else if (!pause_ack) begin
                        // Keep the HPS stalled until the CPU is halted again.
                        state      <= ST_PAUSE;
                        ioctl_wait <= 1'b1;
                    end else begin
                        case (state)
                            ST_PAUSE: begin
                                state      <= ST_READY;
                                ioctl_wait <= 1'b0;
                            end
                            ST_READY: begin
                                // Out-of-range reads stall for a single cycle only.
                                ioctl_wait <= rd_start || rd_fill;
                                if (rd_start) begin
                                    state <= ST_READ;
                                end
                            end
                            ST_READ: begin
                                if (pipe_done) begin
                                    ioctl_wait <= 1'b0;
                                    state      <= ST_READY;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef NVRAM_DIRTY_EN
    logic seen_rd;
    logic seen_dl;
    logic sess_end;

    assign sess_end = (state != ST_IDLE) && !sel;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            nv_dirty <= 1'b0;
            seen_rd  <= 1'b0;
            seen_dl  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                seen_rd <= 1'b0;
                seen_dl <= 1'b0;
            end else begin
                if (rd_start) begin
                    seen_rd <= 1'b1;
                end
                if (sel && ioctl_download) begin
                    seen_dl <= 1'b1;
                end
            end
            // A game write on the same edge as a save/restore completing wins.
            if (cpu_ram_we) begin
                nv_dirty <= 1'b1;
            end else if (sess_end && (seen_rd || seen_dl)) begin
                nv_dirty <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nvram_uploader.sv
// tb/tb_nvram_uploader.sv - self-checking bench for nvram_uploader
module tb_nvram_uploader;

    localparam int         AW     = 10;
    localparam int         SIZE   = 1024;
    localparam int         RD_LAT = 2;
    localparam logic [7:0] IDX    = 8'd4;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ioctl_upload, ioctl_download, ioctl_rd, ioctl_wr, pause_ack;
    logic [7:0]    ioctl_index, ioctl_dout;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait, pause_req;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata;
`ifdef NVRAM_DIRTY_EN
    logic          cpu_ram_we;
    logic          nv_dirty;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk_sys = ~clk_sys;

    nvram_uploader #(
        .INDEX  (IDX),
        .AW     (AW),
        .SIZE   (SIZE),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_upload   (ioctl_upload),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_rd       (ioctl_rd),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .pause_req      (pause_req),
        .pause_ack      (pause_ack),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_rdata      (ram_rdata)
`ifdef NVRAM_DIRTY_EN
        ,
        .cpu_ram_we     (cpu_ram_we),
        .nv_dirty       (nv_dirty)
`endif
    );

    // Power-up RAM image; address 5 holds the byte the directed read expects.
    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (a == 10'd5) ? 8'h3C : (lo * 8'd37 + 8'h11);
    endfunction

    // NVRAM: synchronous write, read data RD_LAT cycles after the address.
    logic [7:0] mem   [0:(1<<AW)-1];
    bit         mem_w [0:(1<<AW)-1];
    logic [7:0] rq    [0:RD_LAT-1];
    always @(posedge clk_sys) begin
        rq[0] <= mem_w[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
        for (int i = 1; i < RD_LAT; i++) rq[i] <= rq[i-1];
        if (ram_we) begin
            mem[ram_addr]   <= ram_wdata;
            mem_w[ram_addr] <= 1'b1;
        end
    end
    assign ram_rdata = rq[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: session / halt / per-read stall counted in cycles.
    logic          e_wait, e_preq, e_we;
    logic [7:0]    e_din, e_wdata;
    logic [AW-1:0] e_addr, rd_addr;
    bit            granted;
    int            rd_left;
    logic [7:0]    model_mem [0:(1<<AW)-1];
    bit            model_w   [0:(1<<AW)-1];

    always @(posedge clk_sys) begin
        bit sel;
        sel  = (ioctl_upload || ioctl_download) && (ioctl_index == IDX);
        e_we = 1'b0;
        if (reset) begin
            e_wait = 0; e_preq = 0; e_din = 8'h00; e_addr = '0; e_wdata = 8'h00;
            granted = 0; rd_left = 0;
        end else if (!e_preq) begin
            if (sel) begin
                e_preq = 1; e_wait = 1; granted = 0;
            end
        end else if (!sel) begin
            e_preq = 0; e_wait = 0; granted = 0; rd_left = 0;
        end else if (!pause_ack) begin
            e_wait = 1; granted = 0; rd_left = 0;
        end else if (!granted) begin
            granted = 1; e_wait = 0;
        end else if (rd_left > 0) begin
            rd_left--;
            if (rd_left == 0) begin
                e_din  = model_w[rd_addr] ? model_mem[rd_addr] : init_val(rd_addr);
                e_wait = 0;
            end
        end else begin
            e_wait = 0;
            if (ioctl_rd) begin
                if (ioctl_addr >= SIZE) begin
                    e_din = 8'hFF; e_wait = 1;
                end else if (ioctl_upload) begin
                    rd_addr = ioctl_addr[AW-1:0];
                    e_addr  = rd_addr;
                    rd_left = RD_LAT + 1;
                    e_wait  = 1;
                end
            end else if (ioctl_wr && ioctl_download && ioctl_addr < SIZE) begin
                e_we    = 1;
                e_addr  = ioctl_addr[AW-1:0];
                e_wdata = ioctl_dout;
                model_mem[e_addr] = ioctl_dout;
                model_w[e_addr]   = 1'b1;
            end
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("cmp_wait",  ioctl_wait, e_wait);
            chk("cmp_preq",  pause_req,  e_preq);
            chk("cmp_din",   ioctl_din,  e_din);
            chk("cmp_addr",  ram_addr,   e_addr);
            chk("cmp_we",    ram_we,     e_we);
            chk("cmp_wdata", ram_wdata,  e_wdata);
        end
    end

    task automatic cyc();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic wait_low(input string name);
        int n = 0;
        while (ioctl_wait && n < 20) begin
            cyc();
            n++;
        end
        chk(name, ioctl_wait, 1'b0);
    endtask

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 9))
            7:       return ($urandom_range(0, 1) != 0) ? 25'd1023 : 25'd1024;
            8:       return 25'($urandom_range(1024, 4095));
            9:       return 25'($urandom);
            default: return 25'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        int n;
        reset = 1; ioctl_upload = 0; ioctl_download = 0; ioctl_index = 8'd0;
        ioctl_rd = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = 8'h00; pause_ack = 0;
`ifdef NVRAM_DIRTY_EN
        cpu_ram_we = 0;
`endif
        cyc();
        chk_en = 1;
        cyc();
        chk("rst_wait", ioctl_wait, 1'b0);
        chk("rst_preq", pause_req, 1'b0);
        chk("rst_din", ioctl_din, 8'h00);
        chk("rst_addr", ram_addr, 10'd0);
        chk("rst_we", ram_we, 1'b0);
        reset = 0;
        cyc();

        // Pause handshake
        ioctl_upload = 1; ioctl_index = IDX; pause_ack = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("hs_preq", pause_req, 1'b1);
            chk("hs_wait", ioctl_wait, 1'b1);
        end
        pause_ack = 1;
        cyc();
        chk("hs_ack_wait", ioctl_wait, 1'b0);

        // In-range read of address 5
        ioctl_rd = 1; ioctl_addr = 25'd5;
        cyc();
        ioctl_rd = 0;
        chk("rd_addr", ram_addr, 10'd5);
        n = 0;
        while (ioctl_wait && n < 20) begin
            n++;
            cyc();
        end
        chk("rd_wait_cycles", n, 3);
        chk("rd_din", ioctl_din, 8'h3C);
        chk("rd_model_din", e_din, 8'h3C);

        // Out-of-range read
        ioctl_rd = 1; ioctl_addr = 25'd1024;
        cyc();
        ioctl_rd = 0;
        chk("oor_wait", ioctl_wait, 1'b1);
        chk("oor_din", ioctl_din, 8'hFF);
        chk("oor_addr", ram_addr, 10'd5);
        cyc();
        chk("oor_wait_drop", ioctl_wait, 1'b0);

        // Abort mid-read
        ioctl_rd = 1; ioctl_addr = 25'd7;
        cyc();
        ioctl_rd = 0; ioctl_upload = 0;
        cyc();
        chk("abort_wait", ioctl_wait, 1'b0);
        chk("abort_preq", pause_req, 1'b0);
        chk("abort_din", ioctl_din, 8'hFF);

        // Restore download
        ioctl_download = 1; ioctl_index = IDX;
        cyc();
        chk("dl_wait", ioctl_wait, 1'b1);
        wait_low("dl_ready");
        ioctl_wr = 1; ioctl_addr = 25'h3FF; ioctl_dout = 8'hA5;
        cyc();
        ioctl_wr = 0;
        chk("dl_we", ram_we, 1'b1);
        chk("dl_addr", ram_addr, 10'h3FF);
        chk("dl_wdata", ram_wdata, 8'hA5);
        chk("dl_nowait", ioctl_wait, 1'b0);
        cyc();
        chk("dl_we_once", ram_we, 1'b0);
        chk("dl_mem", mem[10'h3FF], 8'hA5);
        ioctl_index = 8'd0;
        cyc();
        ioctl_wr = 1; ioctl_addr = 25'd10; ioctl_dout = 8'h77;
        cyc();
        ioctl_wr = 0;
        chk("idx0_we", ram_we, 1'b0);
        cyc();
        chk("idx0_we2", ram_we, 1'b0);
        ioctl_download = 0;
        cyc();

`ifdef NVRAM_DIRTY_EN
        cpu_ram_we = 1;
        cyc();
        cpu_ram_we = 0;
        chk("dirty_set", nv_dirty, 1'b1);
        ioctl_upload = 1; ioctl_index = IDX; pause_ack = 1;
        cyc();
        wait_low("dirty_ready");
        for (int a = 0; a < 16; a++) begin
            ioctl_rd = 1; ioctl_addr = 25'(a);
            cyc();
            ioctl_rd = 0;
            wait_low("dirty_rd");
        end
        chk("dirty_hold", nv_dirty, 1'b1);
        ioctl_upload = 0;
        cyc();
        chk("dirty_clr", nv_dirty, 1'b0);
        cyc();
`endif

        // Randomized sessions
        for (int s = 0; s < 60; s++) begin
            ioctl_index = ($urandom_range(0, 7) == 0) ? 8'd3 : IDX;
            case ($urandom_range(0, 2))
                0:       begin ioctl_upload = 1; ioctl_download = 0; end
                1:       begin ioctl_upload = 0; ioctl_download = 1; end
                default: begin ioctl_upload = 1; ioctl_download = 1; end
            endcase
            pause_ack = 1'($urandom_range(0, 1));
            for (int c = 0; c < 60; c++) begin
                int r;
                reset = 0; ioctl_rd = 0; ioctl_wr = 0;
                r = $urandom_range(0, 99);
                if (r < 4)                    pause_ack = ~pause_ack;
                else if (!pause_ack && r < 30) pause_ack = 1;
                else if (r < 45)              ioctl_rd = 1;
                else if (r < 62)              ioctl_wr = 1;
                else if (r < 67)              begin ioctl_rd = 1; ioctl_wr = 1; end
                else if (r == 99)             reset = 1;
                ioctl_addr = rand_addr();
                ioctl_dout = 8'($urandom);
                cyc();
            end
            reset = 0; ioctl_rd = 0; ioctl_wr = 0;
            ioctl_upload = 0; ioctl_download = 0;
            cyc();
            cyc();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
